fetch_sequencer: RTL and testbench

//  Run/step/halt controller for the instruction fetch unit. Replaces the divided-clock drive of the fetch unit.

---
 rtl/fetch_seq_pkg.sv | 16 +
 rtl/fetch_tick_gen.sv | 35 +++
 rtl/fetch_sequencer.sv | 145 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_seq_pkg.sv
// rtl/fetch_seq_pkg.sv - shared state encoding and default widths for the fetch sequencer
// Purpose: FSM state encoding (visible on the State debug port) and default widths.
package fetch_seq_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_CNT_W  = 16;

  typedef enum logic [2:0] {
    ST_CLEAR   = 3'd0,
    ST_HALT    = 3'd1,
    ST_RUN     = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_CAPTURE = 3'd4
  } state_e;

endpackage

// File: rtl/fetch_tick_gen.sv
// rtl/fetch_tick_gen.sv - terminal-count rate tick for free-run fetching
// Purpose: counts enabled cycles 0..TICK_DIV-1 and flags the last one.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         hold the count at zero
//   en          advance the count this cycle
//   tc          high while enabled on the final count; the count wraps to 0
module fetch_tick_gen #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q;

  assign tc = en && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || tc) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - run/step/halt controller issuing fetch enables and capturing PC/instruction
// Purpose: drives single-cycle FetchEn/FetchRst to the fetch unit, captures each fetched
//   PC/instruction pair for display and counts completed fetches (saturating).
// Optional feature: define BREAKPOINT_EN to add Bkpt/BkptHit and the PC breakpoint compare.
// Ports:
//   Clk, Reset                  clock, asynchronous active-low reset
//   Run, Halt                   levels: free-run request, stop (highest priority)
//   Step, Clear                 one-cycle pulses, honoured only in HALT
//   PCResult, Instruction       current PC and its instruction from the fetch unit
//   FetchEn, FetchRst           one-cycle strobes to the fetch unit PC register
//   DispPC, DispInstr, DispValid  last captured pair and its one-cycle update strobe
//   InstrCount                  fetches since reset/Clear, saturating
//   State                       current FSM state
//   Bkpt, BkptHit               (BREAKPOINT_EN) breakpoint PC and sticky hit flag
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Run,
  input  logic              Step,
  input  logic              Halt,
  input  logic              Clear,
  input  logic [ADDR_W-1:0] PCResult,
  input  logic [ADDR_W-1:0] Instruction,
`ifdef BREAKPOINT_EN
  input  logic [ADDR_W-1:0] Bkpt,
  output logic              BkptHit,
`endif
  output logic              FetchEn,
  output logic              FetchRst,
  output logic [ADDR_W-1:0] DispPC,
  output logic [ADDR_W-1:0] DispInstr,
  output logic              DispValid,
  output logic [CNT_W-1:0]  InstrCount,
  output logic [2:0]        State
);

  state_e              state_q, state_d;
  logic                fetch_en_q, fetch_rst_q, disp_valid_q;
  logic [ADDR_W-1:0]   disp_pc_q, disp_instr_q;
  logic [CNT_W-1:0]    count_q;
  logic                tick_tc;
  logic                run_ok;
  logic                bkpt_stop;

  // Counter is parked at zero outside RUN, so every RUN entry starts a fresh interval.
  fetch_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (Clk),
    .rst_n (Reset),
    .clr   (state_q != ST_RUN),
    .en    (state_q == ST_RUN),
    .tc    (tick_tc)
  );

`ifdef BREAKPOINT_EN
  logic bkpt_hit_q, bkpt_wait_q;
  // After a breakpoint stop, Run must be seen low before HALT will re-enter RUN.
  assign bkpt_stop = Run && (PCResult == Bkpt);
  assign run_ok    = Run && !bkpt_wait_q;
  assign BkptHit   = bkpt_hit_q;
`else
  assign bkpt_stop = 1'b0;
  assign run_ok    = Run;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CLEAR: state_d = ST_HALT;
      ST_HALT: begin
        if (!Halt) begin
          if (Clear)       state_d = ST_CLEAR;
          else if (run_ok) state_d = ST_RUN;
          else if (Step)   state_d = ST_ISSUE;
        end
      end
      ST_RUN: begin
        if (Halt || !Run) state_d = ST_HALT;
        else if (tick_tc) state_d = ST_ISSUE;
      end
      ST_ISSUE: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        // Halt/Run are only looked at here, so an issued fetch always gets captured.
        if (Halt || !Run || bkpt_stop) state_d = ST_HALT;
        else                           state_d = ST_RUN;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_CLEAR;
      fetch_en_q   <= 1'b0;
      fetch_rst_q  <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_pc_q    <= '0;
      disp_instr_q <= '0;
      count_q      <= '0;
`ifdef BREAKPOINT_EN
      bkpt_hit_q   <= 1'b0;
      bkpt_wait_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      // FetchEn is decoded from the next state so it coincides with the ISSUE cycle.
      fetch_en_q   <= (state_d == ST_ISSUE);
      // FetchRst follows the CLEAR cycle, which also yields a pulse after reset release.
      fetch_rst_q  <= (state_q == ST_CLEAR);
      disp_valid_q <= (state_q == ST_CAPTURE);
      if (state_q == ST_CAPTURE) begin
        disp_pc_q    <= PCResult;
        disp_instr_q <= Instruction;
      end
      if (state_q == ST_CLEAR) begin
        count_q <= '0;
      end else if (state_q == ST_CAPTURE && count_q != '1) begin
        count_q <= count_q + CNT_W'(1);
      end
`ifdef BREAKPOINT_EN
      if (state_q == ST_CAPTURE && bkpt_stop) begin
        bkpt_hit_q  <= 1'b1;
        bkpt_wait_q <= 1'b1;
      end else begin
        if (state_q == ST_HALT && state_d != ST_HALT) bkpt_hit_q <= 1'b0;
        if (!Run) bkpt_wait_q <= 1'b0;
      end
`endif
    end
  end

  assign FetchEn    = fetch_en_q;
  assign FetchRst   = fetch_rst_q;
  assign DispPC     = disp_pc_q;
  assign DispInstr  = disp_instr_q;
  assign DispValid  = disp_valid_q;
  assign InstrCount = count_q;
  assign State      = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  localparam int ADDR_W   = 32;
  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 4;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0, step = 1'b0, halt = 1'b0, clear = 1'b0;
  logic [31:0] pc_q;
  logic [31:0] instr;
  logic fetch_en, fetch_rst, disp_valid;
  logic [31:0] disp_pc, disp_instr;
  logic [CNT_W-1:0] instr_count;
  logic [2:0] state;
`ifdef BREAKPOINT_EN
  logic [31:0] bkpt = 32'hFFFF_FFFF;
  logic bkpt_hit;
`endif

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(ADDR_W), .TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
    .Clk(clk), .Reset(rst_n), .Run(run), .Step(step), .Halt(halt), .Clear(clear),
    .PCResult(pc_q), .Instruction(instr),
`ifdef BREAKPOINT_EN
    .Bkpt(bkpt), .BkptHit(bkpt_hit),
`endif
    .FetchEn(fetch_en), .FetchRst(fetch_rst), .DispPC(disp_pc), .DispInstr(disp_instr),
    .DispValid(disp_valid), .InstrCount(instr_count), .State(state)
  );

  // Fetch unit model
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         pc_q <= 32'd0;
    else if (fetch_rst) pc_q <= 32'd0;
    else if (fetch_en)  pc_q <= pc_q + 32'd4;
  end
  assign instr = pc_q ^ 32'hA5A5_0000;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] cnt;
  } exp_t;
  exp_t sb[$];
  logic [31:0] exp_pc = 0;
  int exp_cnt = 0;
  int n_fen = 0;
  int n_frst = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_pc = 0;
      exp_cnt = 0;
    end else begin
      chk("fen_frst_excl", 32'(fetch_en & fetch_rst), 32'd0);
      if (fetch_rst) begin
        n_frst++;
        exp_pc = 0;
        exp_cnt = 0;
      end
      if (fetch_en) begin
        exp_t e;
        n_fen++;
        exp_pc = exp_pc + 32'd4;
        if (exp_cnt != CMAX) exp_cnt++;
        e.pc = exp_pc;
        e.instr = exp_pc ^ 32'hA5A5_0000;
        e.cnt = 32'(exp_cnt);
        sb.push_back(e);
      end
      if (disp_valid) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_dispvalid: got DispValid with no fetch pending, required none");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_disp_pc", disp_pc, e.pc);
          chk("sb_disp_instr", disp_instr, e.instr);
          chk("sb_instr_count", 32'(instr_count), e.cnt);
        end
      end
    end
  end

  typedef struct {
    int run, step, halt, clear;
    int st, fen, frst, dval;
  } vec_t;
  localparam int NV = 30;
  vec_t tbl[NV];

  initial begin
    int n0, n1, first, last;

    // run, step, halt, clear | state, FetchEn, FetchRst, DispValid (one cycle later)
    tbl[0]  = '{0,1,0,0, 3,1,0,0};   // step -> ISSUE next cycle
    tbl[1]  = '{0,0,0,0, 4,0,0,0};
    tbl[2]  = '{0,0,0,0, 1,0,0,1};   // DispValid at T+3
    tbl[3]  = '{0,0,0,0, 1,0,0,0};
    tbl[4]  = '{0,1,1,0, 1,0,0,0};   // Halt beats Step
    tbl[5]  = '{0,1,0,1, 0,0,0,0};   // Clear beats Step
    tbl[6]  = '{0,0,0,0, 1,0,1,0};
    tbl[7]  = '{0,0,0,0, 1,0,0,0};
    tbl[8]  = '{0,1,0,0, 3,1,0,0};
    tbl[9]  = '{0,0,1,0, 4,0,0,0};   // Halt during ISSUE: capture still happens
    tbl[10] = '{0,0,1,0, 1,0,0,1};
    tbl[11] = '{0,0,1,0, 1,0,0,0};
    tbl[12] = '{1,0,0,0, 2,0,0,0};
    tbl[13] = '{1,1,0,0, 2,0,0,0};   // Step in RUN dropped
    tbl[14] = '{1,0,0,0, 2,0,0,0};
    tbl[15] = '{1,0,0,0, 2,0,0,0};
    tbl[16] = '{1,0,0,0, 3,1,0,0};
    tbl[17] = '{1,0,1,0, 4,0,0,0};
    tbl[18] = '{1,0,1,0, 1,0,0,1};
    tbl[19] = '{1,0,0,0, 2,0,0,0};
    tbl[20] = '{0,0,0,0, 1,0,0,0};   // !Run leaves RUN at once
    tbl[21] = '{1,0,0,0, 2,0,0,0};   // tick restarts from 0
    tbl[22] = '{1,0,0,0, 2,0,0,0};
    tbl[23] = '{1,0,0,0, 2,0,0,0};
    tbl[24] = '{1,0,0,0, 2,0,0,0};
    tbl[25] = '{1,0,0,0, 3,1,0,0};
    tbl[26] = '{0,0,0,0, 4,0,0,0};
    tbl[27] = '{0,0,0,0, 1,0,0,1};
    tbl[28] = '{0,0,0,1, 0,0,0,0};
    tbl[29] = '{0,0,0,0, 1,0,1,0};

    // 1: reset mid-RUN
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run = 1'b1;
    repeat (12) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_fetch_en", 32'(fetch_en), 32'd0);
    chk("rst_fetch_rst", 32'(fetch_rst), 32'd0);
    chk("rst_disp_valid", 32'(disp_valid), 32'd0);
    chk("rst_disp_pc", disp_pc, 32'd0);
    chk("rst_disp_instr", disp_instr, 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    repeat (2) @(negedge clk);
    run = 1'b0;
    n0 = n_fen;
    n1 = n_frst;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rel_frst_pulses", 32'(n_frst - n1), 32'd1);
    chk("rel_fetch_en", 32'(n_fen - n0), 32'd0);
    chk("rel_state", 32'(state), 32'd1);
    chk("rel_count", 32'(instr_count), 32'd0);
    chk("rel_disp_pc", disp_pc, 32'd0);
    chk("rel_disp_instr", disp_instr, 32'd0);

    // 2, 4, 5: table-driven single-cycle behaviour
    for (int i = 0; i < NV; i++) begin
      run   = (tbl[i].run != 0);
      step  = (tbl[i].step != 0);
      halt  = (tbl[i].halt != 0);
      clear = (tbl[i].clear != 0);
      @(negedge clk);
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("vec%0d_fetch_en", i), 32'(fetch_en), 32'(tbl[i].fen));
      chk($sformatf("vec%0d_fetch_rst", i), 32'(fetch_rst), 32'(tbl[i].frst));
      chk($sformatf("vec%0d_disp_valid", i), 32'(disp_valid), 32'(tbl[i].dval));
    end
    run = 1'b0; step = 1'b0; halt = 1'b0; clear = 1'b0;
    chk("clear_count", 32'(instr_count), 32'd0);

    // 3: free run, one fetch every TICK_DIV+2 cycles, PCs 4, 8, 12
    n0 = n_fen;
    first = -1;
    last = -1;
    run = 1'b1;
    for (int s = 1; s <= 20; s++) begin
      @(negedge clk);
      if (fetch_en) begin
        if (first < 0) first = s;
        else chk("run_gap", 32'(s - last), 32'd6);
        last = s;
      end
    end
    chk("run_first_fetch", 32'(first), 32'd5);
    chk("run_fetch_count", 32'(n_fen - n0), 32'd3);
    chk("run_last_pc", disp_pc, 32'd12);
    chk("run_last_instr", disp_instr, 32'hA5A5_000C);
    run = 1'b0;
    @(negedge clk);
    chk("run_drop_state", 32'(state), 32'd1);

    // 5b: counter saturation
    run = 1'b1;
    repeat (17 * 6) @(negedge clk);
    run = 1'b0;
    repeat (4) @(negedge clk);
    chk("sat_count", 32'(instr_count), 32'(CMAX));
    n0 = n_fen;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (5) @(negedge clk);
    chk("sat_step_fetch", 32'(n_fen - n0), 32'd1);
    chk("sat_count_hold", 32'(instr_count), 32'(CMAX));

`ifdef BREAKPOINT_EN
    // 6: breakpoint stop and resume
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (3) @(negedge clk);
    bkpt = 32'd12;
    run = 1'b1;
    for (int i = 0; i < 60 && !bkpt_hit; i++) @(negedge clk);
    chk("bkpt_hit_set", 32'(bkpt_hit), 32'd1);
    chk("bkpt_disp_pc", disp_pc, 32'd12);
    n0 = n_fen;
    repeat (10) @(negedge clk);
    chk("bkpt_no_fetch", 32'(n_fen - n0), 32'd0);
    chk("bkpt_state", 32'(state), 32'd1);
    chk("bkpt_hit_sticky", 32'(bkpt_hit), 32'd1);
    run = 1'b0;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    chk("bkpt_resume_state", 32'(state), 32'd2);
    chk("bkpt_hit_clear", 32'(bkpt_hit), 32'd0);
    for (int i = 0; i < 20 && !disp_valid; i++) @(negedge clk);
    chk("bkpt_resume_pc", disp_pc, 32'd16);
    run = 1'b0;
    bkpt = 32'hFFFF_FFFF;
    repeat (4) @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
